// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - RV32 load/store funct3 encodings
//   - memory write-size codes (mem_write) and read-size codes (mem_data)
//   - control state of the misaligned-access sequencer
//   - legality check for a funct3 on a load or a store
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_BYTE = 2'b01;
  localparam logic [1:0] WR_HALF = 2'b10;
  localparam logic [1:0] WR_WORD = 2'b11;

  localparam logic [1:0] RD_BYTE = 2'b00;
  localparam logic [1:0] RD_HALF = 2'b01;
  localparam logic [1:0] RD_WORD = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  // Unsigned variants exist only for loads.
  function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
    if (is_load) return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    else         return f3 inside {F3_B, F3_H, F3_W};
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load result extension.
//   raw         : raw value, meaningful bits in the low byte/half/word
//   size        : RD_BYTE / RD_HALF / RD_WORD
//   is_unsigned : 1 = zero-extend (LBU/LHU), 0 = sign-extend
//   result      : extended value
module load_extend
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] result
);

  always_comb begin
    case (size)
      RD_BYTE: result = {{(XLEN-8){~is_unsigned & raw[7]}}, raw[7:0]};
      RD_HALF: result = {{(XLEN-16){~is_unsigned & raw[15]}}, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// MEM-stage load/store unit: initiator of the byte-addressed data memory.
// Aligned accesses pass straight through in one cycle. Misaligned half/word
// accesses take one accept cycle and then move one byte per cycle, holding
// the pipeline until the cycle that carries the last byte.
//   clk, reset                 : clock, synchronous active-high reset
//   req_valid/load/funct3/addr/wdata : request from the MEM stage
//   stall                      : hold IF..MEM this cycle
//   resp_valid, resp_rdata     : load result (combinational)
//   err                        : illegal funct3 on a request seen in IDLE
//   mem_address, mem_data_in, mem_write, mem_data : to memory
//   mem_data_out               : combinational read data from memory
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_load,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [XLEN-1:0]   mem_data_in,
  output logic [1:0]        mem_write,
  output logic [1:0]        mem_data,
  input  logic [XLEN-1:0]   mem_data_out
);

  state_t            state;
  logic [1:0]        cnt;
  logic [1:0]        last_k;
  logic [ADDR_W-1:0] lat_addr;
  logic [XLEN-1:0]   lat_wdata;
  logic [2:0]        lat_f3;
  logic              lat_load;
  logic [XLEN-1:0]   buffer;

  // Request decode (funct3[1:0] equals the read-size code for legal values).
  logic [1:0] req_size;
  logic       legal;
  logic       aligned;
  logic       go_split;

  assign req_size = req_funct3[1:0];
  assign legal    = f3_legal(req_load, req_funct3);
  assign aligned  = (req_size == RD_BYTE) ||
                    (req_size == RD_HALF && !req_addr[0]) ||
                    (req_size == RD_WORD && req_addr[1:0] == 2'b00);
  assign go_split = (state == IDLE) && req_valid && legal && !aligned;

  // Split path: the byte arriving this cycle merged into the buffer.
  logic            split_last;
  logic [7:0]      wr_byte;
  logic [XLEN-1:0] assembled;

  assign split_last = (cnt == last_k);
  assign wr_byte    = lat_wdata[{cnt, 3'b000} +: 8];

  always_comb begin
    assembled = buffer;
    assembled[{cnt, 3'b000} +: 8] = mem_data_out[7:0];
  end

  // One extender shared by both paths; its inputs follow the state.
  logic [XLEN-1:0] ext_raw;
  logic [1:0]      ext_size;
  logic            ext_unsigned;
  logic [XLEN-1:0] ext_result;

  always_comb begin
    if (state == SPLIT) begin
      ext_raw      = assembled;
      ext_size     = lat_f3[1:0];
      ext_unsigned = lat_f3[2];
    end else begin
      ext_raw      = mem_data_out;
      ext_size     = req_size;
      ext_unsigned = req_funct3[2];
    end
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .raw         (ext_raw),
    .size        (ext_size),
    .is_unsigned (ext_unsigned),
    .result      (ext_result)
  );

  // NOTE: every output gets a default before any branch so the block stays
  // purely combinational; a path that skips an assignment would infer a latch.
  always_comb begin
    stall       = 1'b0;
    resp_valid  = 1'b0;
    resp_rdata  = '0;
    err         = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    mem_write   = WR_NONE;
    mem_data    = RD_BYTE;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (!legal) begin
              err = 1'b1;
            end else if (aligned) begin
              mem_address = req_addr;
              mem_data    = req_size;
              if (req_load) begin
                resp_valid = 1'b1;
                resp_rdata = ext_result;
              end else begin
                case (req_size)
                  RD_BYTE: begin
                    mem_write   = WR_BYTE;
                    mem_data_in = {(XLEN/8){req_wdata[7:0]}};
                  end
                  RD_HALF: begin
                    mem_write   = WR_HALF;
                    mem_data_in = {(XLEN/16){req_wdata[15:0]}};
                  end
                  default: begin
                    mem_write   = WR_WORD;
                    mem_data_in = req_wdata;
                  end
                endcase
              end
            end else begin
              stall = 1'b1;  // accept cycle of a misaligned access
            end
          end
        end
        SPLIT: begin
          // Plain 32-bit add; the memory wraps the address to its own depth.
          mem_address = lat_addr + ADDR_W'(cnt);
          mem_data    = RD_BYTE;
          stall       = !split_last;
          if (!lat_load) begin
            mem_write   = WR_BYTE;
            mem_data_in = {(XLEN/8){wr_byte}};
          end else if (split_last) begin
            resp_valid = 1'b1;
            resp_rdata = ext_result;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      buffer <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go_split) begin
            state  <= SPLIT;
            cnt    <= '0;
            last_k <= (req_size == RD_HALF) ? 2'd1 : 2'd3;
          end
        end
        SPLIT: begin
          if (lat_load) buffer <= assembled;
          if (split_last) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the request latches carry no reset; they are only read in SPLIT,
  // which is always entered through the accept cycle that loads them.
  always_ff @(posedge clk) begin
    if (go_split && !reset) begin
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_f3    <= req_funct3;
      lat_load  <= req_load;
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator with a 1 KiB byte memory model
// (address masked to 10 bits, byte/half reads sign-extended by the memory).
// Load results are pushed to a scoreboard queue when the load is driven and
// popped when the DUT raises resp_valid.
module tb_lsu_mem_initiator;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_load;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, resp_valid, err;
  logic [31:0] resp_rdata, mem_address, mem_data_in, mem_data_out;
  logic [1:0]  mem_write, mem_data;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

  always #5 clk = ~clk;

  lsu_mem_initiator #(.ADDR_W(32), .XLEN(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_load     (req_load),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .err          (err),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_write    (mem_write),
    .mem_data     (mem_data),
    .mem_data_out (mem_data_out)
  );

  // ---------------- memory model ----------------
  logic [7:0] mem [0:1023];
  logic       tb_init;
  logic       pre_we;
  logic [9:0] pre_addr;
  logic [7:0] pre_data;
  logic [9:0] ma0, ma1, ma2, ma3;

  assign ma0 = mem_address[9:0];
  assign ma1 = ma0 + 10'd1;
  assign ma2 = ma0 + 10'd2;
  assign ma3 = ma0 + 10'd3;

  always_comb begin
    case (mem_data)
      2'b00:   mem_data_out = {{24{mem[ma0][7]}}, mem[ma0]};
      2'b01:   mem_data_out = {{16{mem[ma1][7]}}, mem[ma1], mem[ma0]};
      default: mem_data_out = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
    endcase
  end

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else begin
      case (mem_write)
        2'b01: mem[ma0] <= mem_data_in[7:0];
        2'b10: begin
          mem[ma0] <= mem_data_in[7:0];
          mem[ma1] <= mem_data_in[15:8];
        end
        2'b11: begin
          mem[ma0] <= mem_data_in[7:0];
          mem[ma1] <= mem_data_in[15:8];
          mem[ma2] <= mem_data_in[23:16];
          mem[ma3] <= mem_data_in[31:24];
        end
        default: ;
      endcase
    end
  end

  // ---------------- check helper ----------------
  task automatic check(input logic ok, input string msg);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL %s", msg);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive_req(input logic v, input logic l, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d);
    req_valid  = v;
    req_load   = l;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    drive_req(1'b0, 1'b0, F3_B, 32'h0, 32'h0);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    next_cycle();
    pre_we = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_req(1'b1, 1'b0, F3_W, 32'h100, 32'hDEADBEEF);
    @(negedge clk);
    check({stall, resp_valid, err} === 3'b000,
          $sformatf("reset_ctrl: stall/resp_valid/err=%b expected 000", {stall, resp_valid, err}));
    check(mem_write === 2'b00,
          $sformatf("reset_mem_write: got %b expected 00", mem_write));
    check(mem_address === 32'h0 && mem_data_in === 32'h0 && resp_rdata === 32'h0,
          $sformatf("reset_data: addr=%h din=%h rdata=%h expected all 0", mem_address, mem_data_in, resp_rdata));
    next_cycle();
    reset   = 1'b0;
    tb_init = 1'b0;
    drive_req(1'b0, 1'b0, F3_B, 32'h0, 32'h0);
    next_cycle();
  endtask

  task automatic test_aligned();
    drive_req(1'b1, 1'b0, F3_W, 32'h100, 32'hDEADBEEF);
    @(negedge clk);
    check(mem_write === 2'b11 && mem_address === 32'h100,
          $sformatf("sw_aligned: mem_write=%b addr=%h expected 11 / 00000100", mem_write, mem_address));
    check(stall === 1'b0 && err === 1'b0 && mem_data_in === 32'hDEADBEEF,
          $sformatf("sw_aligned_misc: stall=%b err=%b din=%h expected 0 0 deadbeef", stall, err, mem_data_in));
    next_cycle();
    drive_req(1'b1, 1'b1, F3_W, 32'h100, 32'h0);
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    check(resp_valid === 1'b1 && stall === 1'b0 && mem_write === 2'b00,
          $sformatf("lw_aligned_ctrl: resp_valid=%b stall=%b mem_write=%b expected 1 0 00", resp_valid, stall, mem_write));
    if (resp_valid === 1'b1) begin
      exp = exp_q.pop_front();
      check(resp_rdata === exp,
            $sformatf("lw_aligned_data: got %h expected %h", resp_rdata, exp));
    end
    next_cycle();
  endtask

  task automatic test_sign_ext();
    logic [2:0]  f3s  [4] = '{F3_B, F3_BU, F3_HU, F3_H};
    logic [31:0] adrs [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
    logic [31:0] exps [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'h0000DEAD, 32'hFFFFDEAD};
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b1, 1'b1, f3s[i], adrs[i], 32'h0);
      exp_q.push_back(exps[i]);
      @(negedge clk);
      check(resp_valid === 1'b1 && stall === 1'b0,
            $sformatf("ext_%0d_ctrl: resp_valid=%b stall=%b expected 1 0", i, resp_valid, stall));
      if (resp_valid === 1'b1) begin
        exp = exp_q.pop_front();
        check(resp_rdata === exp,
              $sformatf("ext_%0d_data: got %h expected %h", i, resp_rdata, exp));
      end
      next_cycle();
    end
  endtask

  task automatic test_misaligned_store();
    logic [31:0] wd = 32'h11223344;
    logic [7:0]  eb;
    drive_req(1'b1, 1'b0, F3_W, 32'h201, wd);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check(stall === 1'b1 && mem_write === 2'b00,
              $sformatf("ms_accept: stall=%b mem_write=%b expected 1 00", stall, mem_write));
      end else begin
        eb = 8'(wd >> (8 * (k - 1)));
        check(mem_write === 2'b01 && mem_address === 32'h201 + 32'(k - 1) && mem_data_in[7:0] === eb,
              $sformatf("ms_byte%0d: wr=%b addr=%h byte=%h expected 01 %h %h",
                        k, mem_write, mem_address, mem_data_in[7:0], 32'h201 + 32'(k - 1), eb));
        check(stall === (k < 4),
              $sformatf("ms_stall%0d: got %b expected %b", k, stall, (k < 4)));
      end
      next_cycle();
    end
    drive_req(1'b1, 1'b1, F3_W, 32'h201, 32'h0);
    exp_q.push_back(32'h11223344);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check(stall === (k < 4) && resp_valid === (k == 4),
            $sformatf("ml_cycle%0d: stall=%b resp_valid=%b expected %b %b", k, stall, resp_valid, (k < 4), (k == 4)));
      if (resp_valid === 1'b1) begin
        exp = exp_q.pop_front();
        check(resp_rdata === exp,
              $sformatf("ml_data: got %h expected %h", resp_rdata, exp));
      end
      next_cycle();
    end
  endtask

  task automatic test_wrap();
    logic [7:0]  b0s  [3] = '{8'h7F, 8'hFF, 8'hFF};
    logic [2:0]  f3s  [3] = '{F3_H, F3_HU, F3_H};
    logic [31:0] exps [3] = '{32'h00007F80, 32'h0000FF80, 32'hFFFFFF80};
    preload(10'h3FF, 8'h80);
    for (int i = 0; i < 3; i++) begin
      preload(10'h000, b0s[i]);
      drive_req(1'b1, 1'b1, f3s[i], 32'h3FF, 32'h0);
      exp_q.push_back(exps[i]);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check(stall === (k < 2) && resp_valid === (k == 2),
              $sformatf("wrap%0d_c%0d: stall=%b resp_valid=%b expected %b %b", i, k, stall, resp_valid, (k < 2), (k == 2)));
        if (k > 0) begin
          check(mem_address === 32'h3FF + 32'(k - 1),
                $sformatf("wrap%0d_addr%0d: got %h expected %h", i, k, mem_address, 32'h3FF + 32'(k - 1)));
        end
        if (resp_valid === 1'b1) begin
          exp = exp_q.pop_front();
          check(resp_rdata === exp,
                $sformatf("wrap%0d_data: got %h expected %h", i, resp_rdata, exp));
        end
        next_cycle();
      end
    end
  endtask

  task automatic test_illegal();
    logic       lds [2] = '{1'b1, 1'b0};
    logic [2:0] f3s [2] = '{3'b011, 3'b100};
    for (int i = 0; i < 2; i++) begin
      drive_req(1'b1, lds[i], f3s[i], 32'h100, 32'h12345678);
      @(negedge clk);
      check(err === 1'b1 && mem_write === 2'b00 && resp_valid === 1'b0 && stall === 1'b0,
            $sformatf("illegal%0d: err=%b wr=%b rv=%b stall=%b expected 1 00 0 0", i, err, mem_write, resp_valid, stall));
      next_cycle();
    end
    // Still IDLE: an aligned load answers in the same cycle.
    drive_req(1'b1, 1'b1, F3_BU, 32'h100, 32'h0);
    exp_q.push_back(32'h000000EF);
    @(negedge clk);
    check(resp_valid === 1'b1 && stall === 1'b0 && err === 1'b0,
          $sformatf("illegal_after: rv=%b stall=%b err=%b expected 1 0 0", resp_valid, stall, err));
    if (resp_valid === 1'b1) begin
      exp = exp_q.pop_front();
      check(resp_rdata === exp,
            $sformatf("illegal_after_data: got %h expected %h", resp_rdata, exp));
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_split();
    drive_req(1'b1, 1'b0, F3_W, 32'h301, 32'hAABBCCDD);
    @(negedge clk);
    check(stall === 1'b1,
          $sformatf("rs_accept: stall=%b expected 1", stall));
    next_cycle();
    @(negedge clk);
    check(mem_write === 2'b01 && mem_address === 32'h301 && mem_data_in[7:0] === 8'hDD,
          $sformatf("rs_byte0: wr=%b addr=%h byte=%h expected 01 00000301 dd", mem_write, mem_address, mem_data_in[7:0]));
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check(mem_write === 2'b00 && stall === 1'b0 && resp_valid === 1'b0,
          $sformatf("rs_in_reset: wr=%b stall=%b rv=%b expected 00 0 0", mem_write, stall, resp_valid));
    next_cycle();
    reset = 1'b0;
    drive_req(1'b1, 1'b1, F3_W, 32'h300, 32'h0);
    exp_q.push_back(32'h0000DD00);
    @(negedge clk);
    check(stall === 1'b0 && resp_valid === 1'b1,
          $sformatf("rs_after: stall=%b rv=%b expected 0 1", stall, resp_valid));
    if (resp_valid === 1'b1) begin
      exp = exp_q.pop_front();
      check(resp_rdata === exp,
            $sformatf("rs_after_data: got %h expected %h", resp_rdata, exp));
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    // Misaligned LHU 0x203 then aligned LB 0x204 on the very next cycle.
    drive_req(1'b1, 1'b1, F3_HU, 32'h203, 32'h0);
    exp_q.push_back(32'h00001122);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check(stall === (k < 2) && resp_valid === (k == 2),
            $sformatf("b2b_c%0d: stall=%b rv=%b expected %b %b", k, stall, resp_valid, (k < 2), (k == 2)));
      if (resp_valid === 1'b1) begin
        exp = exp_q.pop_front();
        check(resp_rdata === exp,
              $sformatf("b2b_split_data: got %h expected %h", resp_rdata, exp));
      end
      next_cycle();
    end
    drive_req(1'b1, 1'b1, F3_B, 32'h204, 32'h0);
    exp_q.push_back(32'h00000011);
    @(negedge clk);
    check(stall === 1'b0 && resp_valid === 1'b1,
          $sformatf("b2b_next: stall=%b rv=%b expected 0 1", stall, resp_valid));
    if (resp_valid === 1'b1) begin
      exp = exp_q.pop_front();
      check(resp_rdata === exp,
            $sformatf("b2b_next_data: got %h expected %h", resp_rdata, exp));
    end
    next_cycle();
    drive_req(1'b0, 1'b0, F3_B, 32'h0, 32'h0);
  endtask

  initial begin
    reset   = 1'b1;
    tb_init = 1'b1;
    pre_we  = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    drive_req(1'b0, 1'b0, F3_B, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_aligned();
    test_sign_ext();
    test_misaligned_store();
    test_wrap();
    test_illegal();
    test_reset_mid_split();
    test_back_to_back();
    check(exp_q.size() == 0,
          $sformatf("scoreboard_drain: %0d responses missing, expected 0", exp_q.size()));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
